// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// A MEM-stage stall never drops or reorders a beat. Flush kills everything in flight.
module ex_mem_skid_reg #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_ALUResult,
  input  logic [DATA_W-1:0] in_WriteData,
  input  logic              in_Zero,
  input  logic              in_SSSrc,
  input  logic              in_RegWrite,
  input  logic              in_MemWrite,
  input  logic [1:0]        in_ResultSrc,
  input  logic [RD_W-1:0]   in_Rd,
  input  logic [DATA_W-1:0] in_PCPlus4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_ALUResult,
  output logic [DATA_W-1:0] out_WriteData,
  output logic              out_Zero,
  output logic              out_SSSrc,
  output logic              out_RegWrite,
  output logic              out_MemWrite,
  output logic [1:0]        out_ResultSrc,
  output logic [RD_W-1:0]   out_Rd,
  output logic [DATA_W-1:0] out_PCPlus4,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wd;
    logic              zero;
    logic              sssrc;
    logic              regwrite;
    logic              memwrite;
    logic [1:0]        resultsrc;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] pc4;
  } beat_t;

  beat_t in_beat;
  beat_t main_q;
  beat_t skid_q;
  logic  main_valid;
  logic  skid_valid;
  logic  accept;
  logic  release_beat;

  always_comb begin
    in_beat           = '0;
    in_beat.alu       = in_ALUResult;
    in_beat.wd        = in_WriteData;
    in_beat.zero      = in_Zero;
    in_beat.sssrc     = in_SSSrc;
    in_beat.regwrite  = in_RegWrite;
    in_beat.memwrite  = in_MemWrite;
    in_beat.resultsrc = in_ResultSrc;
    in_beat.rd        = in_Rd;
    in_beat.pc4       = in_PCPlus4;
  end

  // The skid entry exists only to absorb the beat accepted while MEM stalls,
  // so a full skid is the sole reason to refuse input.
  assign in_ready     = ~skid_valid & ~reset;
  assign accept       = in_valid & in_ready;
  assign release_beat = main_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (release_beat && !accept) begin
      main_valid <= skid_valid;
      skid_valid <= 1'b0;
      if (skid_valid) begin
        main_q <= skid_q;
      end
    end else if (accept && (!main_valid || release_beat)) begin
      main_valid <= 1'b1;
      main_q     <= in_beat;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_q     <= in_beat;
    end
  end

  // Write enables are masked so an empty slot can never commit a write.
  assign out_valid     = main_valid;
  assign out_ALUResult = main_q.alu;
  assign out_WriteData = main_q.wd;
  assign out_Zero      = main_q.zero;
  assign out_SSSrc     = main_q.sssrc;
  assign out_RegWrite  = main_q.regwrite & main_valid;
  assign out_MemWrite  = main_q.memwrite & main_valid;
  assign out_ResultSrc = main_q.resultsrc;
  assign out_Rd        = main_q.rd;
  assign out_PCPlus4   = main_q.pc4;
  assign occupancy     = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Self-checking bench for ex_mem_skid_reg: a table of one-cycle vectors plus a SIMD stall sequence.
module tb_ex_mem_skid_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ALUResult;
  logic [31:0] in_WriteData;
  logic        in_Zero;
  logic        in_SSSrc;
  logic        in_RegWrite;
  logic        in_MemWrite;
  logic [1:0]  in_ResultSrc;
  logic [4:0]  in_Rd;
  logic [31:0] in_PCPlus4;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ALUResult;
  logic [31:0] out_WriteData;
  logic        out_Zero;
  logic        out_SSSrc;
  logic        out_RegWrite;
  logic        out_MemWrite;
  logic [1:0]  out_ResultSrc;
  logic [4:0]  out_Rd;
  logic [31:0] out_PCPlus4;
  logic [1:0]  occupancy;

  int passCount = 0;
  int checkCount = 0;

  ex_mem_skid_reg #(.DATA_W(32), .RD_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ALUResult(in_ALUResult), .in_WriteData(in_WriteData), .in_Zero(in_Zero),
    .in_SSSrc(in_SSSrc), .in_RegWrite(in_RegWrite), .in_MemWrite(in_MemWrite),
    .in_ResultSrc(in_ResultSrc), .in_Rd(in_Rd), .in_PCPlus4(in_PCPlus4),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ALUResult(out_ALUResult), .out_WriteData(out_WriteData), .out_Zero(out_Zero),
    .out_SSSrc(out_SSSrc), .out_RegWrite(out_RegWrite), .out_MemWrite(out_MemWrite),
    .out_ResultSrc(out_ResultSrc), .out_Rd(out_Rd), .out_PCPlus4(out_PCPlus4),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Side fields of a table beat are derived from its ALU value so every field is checked.
  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic        ordy;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic        eValid;
    logic        eReady;
    logic [1:0]  eOcc;
    logic        eClr;
    logic [31:0] eAlu;
    logic [4:0]  eRd;
    logic        eRw;
    logic        eMw;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input vec_t v);
    reset        = v.rst;
    flush        = v.fl;
    in_valid     = v.iv;
    out_ready    = v.ordy;
    in_ALUResult = v.alu;
    in_WriteData = v.alu ^ 32'hA5A5_0000;
    in_PCPlus4   = v.alu + 32'h0000_1000;
    in_Zero      = v.alu[0];
    in_SSSrc     = v.alu[1];
    in_ResultSrc = v.alu[3:2];
    in_Rd        = v.rd;
    in_RegWrite  = v.rw;
    in_MemWrite  = v.mw;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    logic [31:0] a;
    a = v.eClr ? 32'h0 : v.eAlu;
    check($sformatf("v%0d_out_valid", idx), {31'h0, out_valid}, {31'h0, v.eValid});
    check($sformatf("v%0d_in_ready", idx), {31'h0, in_ready}, {31'h0, v.eReady});
    check($sformatf("v%0d_occupancy", idx), {30'h0, occupancy}, {30'h0, v.eOcc});
    check($sformatf("v%0d_RegWrite", idx), {31'h0, out_RegWrite}, {31'h0, v.eRw});
    check($sformatf("v%0d_MemWrite", idx), {31'h0, out_MemWrite}, {31'h0, v.eMw});
    check($sformatf("v%0d_ALUResult", idx), out_ALUResult, a);
    check($sformatf("v%0d_Rd", idx), {27'h0, out_Rd}, v.eClr ? 32'h0 : {27'h0, v.eRd});
    check($sformatf("v%0d_WriteData", idx), out_WriteData, v.eClr ? 32'h0 : (a ^ 32'hA5A5_0000));
    check($sformatf("v%0d_PCPlus4", idx), out_PCPlus4, v.eClr ? 32'h0 : (a + 32'h0000_1000));
    check($sformatf("v%0d_misc", idx), {28'h0, out_ResultSrc, out_SSSrc, out_Zero},
          v.eClr ? 32'h0 : {28'h0, a[3:2], a[1], a[0]});
  endtask

  initial begin
    // rst fl iv ordy alu rd rw mw | valid ready occ clr alu rd rw mw
    vecs[0]  = '{1,0,0,0, 32'h0,      5'd0,  0,0,  0,0,2'd0,1, 32'h0,      5'd0,  0,0};
    vecs[1]  = '{0,0,1,1, 32'h5,      5'd3,  1,0,  1,1,2'd1,0, 32'h5,      5'd3,  1,0};
    vecs[2]  = '{0,0,1,1, 32'h11,     5'd1,  1,0,  1,1,2'd1,0, 32'h11,     5'd1,  1,0};
    vecs[3]  = '{0,0,1,1, 32'h22,     5'd2,  0,1,  1,1,2'd1,0, 32'h22,     5'd2,  0,1};
    vecs[4]  = '{0,0,1,1, 32'h33,     5'd3,  1,0,  1,1,2'd1,0, 32'h33,     5'd3,  1,0};
    vecs[5]  = '{0,0,0,1, 32'h0,      5'd0,  0,0,  0,1,2'd0,0, 32'h33,     5'd3,  0,0};
    vecs[6]  = '{0,0,1,0, 32'hA,      5'd10, 1,0,  1,1,2'd1,0, 32'hA,      5'd10, 1,0};
    vecs[7]  = '{0,0,1,0, 32'hB,      5'd11, 1,1,  1,0,2'd2,0, 32'hA,      5'd10, 1,0};
    vecs[8]  = '{0,0,1,0, 32'hD,      5'd13, 1,1,  1,0,2'd2,0, 32'hA,      5'd10, 1,0};
    vecs[9]  = '{0,0,0,1, 32'h0,      5'd0,  0,0,  1,1,2'd1,0, 32'hB,      5'd11, 1,1};
    vecs[10] = '{0,0,0,1, 32'h0,      5'd0,  0,0,  0,1,2'd0,0, 32'hB,      5'd11, 0,0};
    vecs[11] = '{0,0,1,0, 32'hA1,     5'd4,  1,0,  1,1,2'd1,0, 32'hA1,     5'd4,  1,0};
    vecs[12] = '{0,0,1,0, 32'hB1,     5'd5,  1,0,  1,0,2'd2,0, 32'hA1,     5'd4,  1,0};
    vecs[13] = '{0,1,1,0, 32'hC,      5'd6,  1,1,  0,1,2'd0,0, 32'hA1,     5'd4,  0,0};
    vecs[14] = '{0,0,0,1, 32'h0,      5'd0,  0,0,  0,1,2'd0,0, 32'hA1,     5'd4,  0,0};
    vecs[15] = '{0,0,1,0, 32'h77,     5'd7,  1,0,  1,1,2'd1,0, 32'h77,     5'd7,  1,0};
    vecs[16] = '{0,0,1,0, 32'h88,     5'd8,  1,0,  1,0,2'd2,0, 32'h77,     5'd7,  1,0};
    vecs[17] = '{1,0,1,0, 32'h99,     5'd9,  1,1,  0,0,2'd0,1, 32'h0,      5'd0,  0,0};
    vecs[18] = '{0,0,0,0, 32'h0,      5'd0,  0,0,  0,1,2'd0,1, 32'h0,      5'd0,  0,0};
    vecs[19] = '{0,0,1,0, 32'h55,     5'd21, 1,0,  1,1,2'd1,0, 32'h55,     5'd21, 1,0};
    vecs[20] = '{1,1,0,0, 32'h0,      5'd0,  0,0,  0,0,2'd0,1, 32'h0,      5'd0,  0,0};
    vecs[21] = '{0,0,1,1, 32'h44,     5'd12, 1,0,  1,1,2'd1,0, 32'h44,     5'd12, 1,0};
    vecs[22] = '{0,1,1,1, 32'h66,     5'd14, 1,1,  0,1,2'd0,0, 32'h44,     5'd12, 0,0};

    applyStimulus(vecs[0]);
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput(i, vecs[i]);
    end

    // SIMD store beat held through a three-cycle MEM stall, then released once.
    reset        = 1'b0;
    flush        = 1'b0;
    in_valid     = 1'b1;
    out_ready    = 1'b0;
    in_ALUResult = 32'h1234_5678;
    in_WriteData = 32'hDEAD_BEEF;
    in_PCPlus4   = 32'h0000_0040;
    in_Zero      = 1'b0;
    in_SSSrc     = 1'b1;
    in_ResultSrc = 2'd1;
    in_Rd        = 5'd9;
    in_RegWrite  = 1'b0;
    in_MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    in_WriteData = 32'h0;
    in_SSSrc     = 1'b0;
    in_MemWrite  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("simd_stall%0d_valid", c), {31'h0, out_valid}, 32'h1);
      check($sformatf("simd_stall%0d_WriteData", c), out_WriteData, 32'hDEAD_BEEF);
      check($sformatf("simd_stall%0d_SSSrc", c), {31'h0, out_SSSrc}, 32'h1);
      check($sformatf("simd_stall%0d_MemWrite", c), {31'h0, out_MemWrite}, 32'h1);
      check($sformatf("simd_stall%0d_ALUResult", c), out_ALUResult, 32'h1234_5678);
      if (c < 2) begin
        @(posedge clk);
        #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("simd_released_valid", {31'h0, out_valid}, 32'h0);
    check("simd_released_MemWrite", {31'h0, out_MemWrite}, 32'h0);
    check("simd_released_occupancy", {30'h0, occupancy}, 32'h0);
    @(posedge clk);
    #1;
    check("simd_no_duplicate", {31'h0, out_valid}, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
- EX→MEM pipeline boundary. It sits directly downstream of the execute-stage ALU unit.
- Captures ALU outputs (scalar or SIMD-array result, store data, Zero flag) plus the writeback/memory control bits that travel with them.
- Provides a valid/ready handshake with a 2-entry skid buffer, so a memory-stage stall never drops or reorders an executed instruction.
- A synchronous flush kills in-flight entries on branch mispredict.

Parameters:
- DATA_W, 32, width of ALUResult, WriteData and PCPlus4 paths.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all buffered entries and of the current input beat.
- in_valid  in  1  EX stage presents a valid instruction.
- in_ready  out  1  block can accept a beat this cycle.
- in_ALUResult  in  DATA_W  selected ALU result (scalar or array).
- in_WriteData  in  DATA_W  store data (rs2 value).
- in_Zero  in  1  ALU zero flag.
- in_SSSrc  in  1  1 = result came from ALU array.
- in_RegWrite  in  1  register-file write enable.
- in_MemWrite  in  1  data-memory write enable.
- in_ResultSrc  in  2  writeback mux select.
- in_Rd  in  RD_W  destination register.
- in_PCPlus4  in  DATA_W  PC+4 for link writeback.
- out_valid  out  1  MEM stage has a valid instruction.
- out_ready  in  1  MEM stage consumes the beat this cycle.
- out_ALUResult, out_WriteData, out_Zero, out_SSSrc, out_RegWrite, out_MemWrite, out_ResultSrc, out_Rd, out_PCPlus4  out  (as inputs)  registered copies.
- occupancy  out  2  number of valid entries held (0..2).

Behaviour:
- Storage: main register (drives out_*) and skid register, each with its own valid bit.
- Accept: in_valid & in_ready. Release: out_valid & out_ready.
- in_ready = ~skid_valid & ~reset (combinational from state).
- Latency: a beat accepted at edge N appears on out_* after edge N (one-cycle latency) when the buffer is empty.
- Per-edge update, with flush and reset clear:
  - Release and not accept: main ← skid (if skid valid), skid cleared.
  - Accept and main empty: main ← input.
  - Accept and main valid and release: main ← input (skid must be empty, since in_ready=1).
  - Accept and main valid and no release: skid ← input.
  - Neither: hold.
- Order is strictly FIFO; the skid entry always drains into main before any newer beat.
- out_valid = main_valid.
- out_RegWrite and out_MemWrite are gated by main_valid, so bubbles never write.
- Other data fields hold their last value when invalid.
- occupancy = main_valid + skid_valid. The value 2 implies in_ready=0.
- flush=1:
  - Both valid bits clear at the edge; the input beat that cycle is not captured.
  - A release in the same cycle still counts as consumed by MEM.
  - flush has priority over accept.
- reset=1:
  - All valid bits clear and all out_* data registers go to 0; occupancy=0 and in_ready=0.
  - First accept is possible on the cycle after reset deasserts.
  - Reset mid-stall discards both entries.
- Simultaneous reset and flush: reset wins (same result).
- out_ready is ignored while out_valid=0.
- No combinational path from in_* data to out_*.

Test Plan:
- Reset, then in_valid=1, in_ALUResult=32'h0000_0005, in_Rd=5'd3, in_RegWrite=1, out_ready=1 -> out_valid=1 next cycle with ALUResult=5, Rd=3, RegWrite=1; occupancy=1.
- Back-to-back stream A=0x11, B=0x22, C=0x33, out_ready=1 throughout -> outputs 0x11, 0x22, 0x33 on consecutive cycles; in_ready stays 1.
- out_ready=0 while sending A=0xA, B=0xB -> occupancy 1 then 2; in_ready=0 after B; raise out_ready -> 0xA then 0xB appear in order, with no loss or duplication.
- Buffer full (A, B), assert flush with in_valid=1 carrying C=0xC -> next cycle out_valid=0, out_RegWrite=0, out_MemWrite=0, occupancy=0; C never appears.
- Assert reset while occupancy=2 -> next cycle out_valid=0, all out_* data 0, in_ready=0 during reset, 1 the cycle after deassertion.
- SIMD beat: in_SSSrc=1, in_MemWrite=1, in_WriteData=32'hDEAD_BEEF, MEM stalls 3 cycles -> out_* held stable for all 3 cycles, then released exactly once.
